// File: rtl/bus_sampler.sv
// Scans a shared tri-state byte bus: grants each enabled source in turn, samples
// its value after a settle cycle and queues {source, data} in a small capture FIFO.
module bus_sampler #(
    parameter int NUM_SRC    = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               scan_req,
    input  logic [NUM_SRC-1:0] src_mask,
    output logic [NUM_SRC-1:0] out_en,
    input  logic [7:0]         bus_in,
    output logic               busy,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [7:0]         rd_data,
    output logic [SRC_W-1:0]   rd_src,
    output logic               overflow,
    input  logic               ovf_clr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        SAMPLE = 2'd2,
        TURN   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [SRC_W-1:0]   sel_q, sel_d;
    logic [NUM_SRC-1:0] out_en_q, out_en_d;
    logic               busy_q, busy_d;

    logic [NUM_SRC-1:0] cand_s;
    logic               found_s;
    logic [SRC_W-1:0]   first_idx_s;
    logic               grant_s;

    logic [7:0]         mem_data_q [FIFO_DEPTH];
    logic [SRC_W-1:0]   mem_src_q  [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               push_s, full_s, empty_s, push_ok_s, pop_s;

    // Candidate sources: the request mask in IDLE, remaining higher mask bits in TURN.
    always_comb begin
        cand_s = '0;
        case (state_q)
            IDLE: begin
                cand_s = src_mask;
            end
            TURN: begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    cand_s[i] = mask_q[i] & (i > int'(sel_q));
                end
            end
            default: begin
                cand_s = '0;
            end
        endcase
    end

    // Lowest set candidate bit wins.
    always_comb begin
        found_s     = 1'b0;
        first_idx_s = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            first_idx_s = cand_s[i] ? SRC_W'(i) : first_idx_s;
            found_s     = found_s | cand_s[i];
        end
    end

    // Scan FSM next-state and registered-output next values.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (scan_req && found_s) begin
                    mask_d  = src_mask;
                    sel_d   = first_idx_s;
                    state_d = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                state_d = SAMPLE;
            end
            SAMPLE: begin
                state_d = TURN;
            end
            TURN: begin
                if (found_s) begin
                    sel_d   = first_idx_s;
                    state_d = GRANT;
                end else begin
                    mask_d  = '0;
                    sel_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                mask_d  = '0;
                sel_d   = '0;
                state_d = IDLE;
            end
        endcase

        grant_s = (state_d == GRANT) || (state_d == SAMPLE);
        for (int i = 0; i < NUM_SRC; i++) begin
            out_en_d[i] = grant_s && (sel_d == SRC_W'(i));
        end
        busy_d = (state_d != IDLE);
    end

    // FSM state, latched mask, selected source and registered bus enables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            sel_q    <= '0;
            out_en_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            sel_q    <= sel_d;
            out_en_q <= out_en_d;
            busy_q   <= busy_d;
        end
    end

    // Full is judged on the registered count, so a pop cannot rescue a push.
    always_comb begin
        push_s    = (state_q == SAMPLE);
        full_s    = (count_q == CNT_W'(FIFO_DEPTH));
        empty_s   = (count_q == '0);
        push_ok_s = push_s & ~full_s;
        pop_s     = rd_ready & ~empty_s;

        if (push_ok_s) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (push_s && full_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Capture storage; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_q[i] <= 8'h00;
                mem_src_q[i]  <= '0;
            end
        end else if (push_ok_s) begin
            mem_data_q[wr_ptr_q] <= bus_in;
            mem_src_q[wr_ptr_q]  <= sel_q;
        end else begin
            mem_data_q[wr_ptr_q] <= mem_data_q[wr_ptr_q];
            mem_src_q[wr_ptr_q]  <= mem_src_q[wr_ptr_q];
        end
    end

    assign out_en   = out_en_q;
    assign busy     = busy_q;
    assign rd_valid = ~empty_s;
    assign rd_data  = mem_data_q[rd_ptr_q];
    assign rd_src   = mem_src_q[rd_ptr_q];
    assign overflow = ovf_q;

endmodule
